// File: rtl/spi_regif_slave_if.sv
// Bus bundle between a SPI register-access slave and its surroundings:
// the SPI pin side plus the register-file access side.
interface spi_regif_slave_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              sclk;
   logic              mosi;
   logic              cs;
   logic              miso;
   logic              miso_oe;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_wr;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] data_rd_i;
   logic              abort;

   modport slave (
      input  sclk, mosi, cs, data_rd_i,
      output miso, miso_oe, addr, data_wr, wr_en, rd_en, abort
   );

   modport master (
      output sclk, mosi, cs, data_rd_i,
      input  miso, miso_oe, addr, data_wr, wr_en, rd_en, abort
   );
endinterface

// File: rtl/spi_regif_slave.sv
// SPI slave register-access port, oversampled on clk: command word (R/W + address)
// followed by one or more data words, with optional address auto-increment bursts.
module spi_regif_slave #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 1,
   parameter int SYNC_STAGES = 2,
   parameter int BURST_EN    = 1
) (
   input logic               clk,
   input logic               rst_n,
   spi_regif_slave_if.slave  bus
);
   localparam int CMD_W  = ADDR_W + 1;
   localparam int SH_W   = (CMD_W > DATA_W) ? CMD_W : DATA_W;
   localparam int CNT_W  = $clog2(SH_W + 1);
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic             C_IDLE    = (CPOL != 0);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_LOAD, S_WRITE, S_WR_INC, S_READ, S_RD_INC, S_DONE
   } state_t;

   state_t            r_state, w_state_next;
   logic [SYNC_N-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
   logic              r_sclk_d, r_cs_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic [SH_W-1:0]   r_shift, w_shift_next, w_shift_in;
   logic [DATA_W-1:0] r_tx, w_tx_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic [DATA_W-1:0] r_data_wr, w_data_wr_next;
   logic              r_wr_en, w_wr_en_next;
   logic              r_rd_en, w_rd_en_next;
   logic              r_abort, w_abort_next;
   logic              r_miso, w_miso_next;
   logic              r_miso_oe, w_miso_oe_next;

   logic w_sclk_s, w_mosi_s, w_cs_s, w_cs_pre;
   logic w_lead, w_trail, w_sample, w_shift, w_cs_fall, w_cs_rise, w_rd_state;

   assign w_sclk_s  = r_sclk_sync[SYNC_N-1];
   assign w_mosi_s  = r_mosi_sync[SYNC_N-1];
   assign w_cs_s    = r_cs_sync[SYNC_N-1];
   assign w_cs_pre  = r_cs_sync[SYNC_N-2];
   assign w_lead    = (w_sclk_s != C_IDLE) && (r_sclk_d == C_IDLE) && !w_cs_s;
   assign w_trail   = (w_sclk_s == C_IDLE) && (r_sclk_d != C_IDLE) && !w_cs_s;
   assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
   assign w_shift   = (CPHA != 0) ? w_lead : w_trail;
   assign w_cs_fall = r_cs_d && !w_cs_s;
   assign w_cs_rise = !r_cs_d && w_cs_s;
   assign w_shift_in = {r_shift[SH_W-2:0], w_mosi_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_shift_next   = r_shift;
      w_tx_next      = r_tx;
      w_addr_next    = r_addr;
      w_data_wr_next = r_data_wr;
      w_wr_en_next   = 1'b0;
      w_rd_en_next   = 1'b0;
      w_abort_next   = 1'b0;
      w_miso_next    = r_miso;
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall) begin
               w_state_next = S_CMD;
               w_cnt_next   = '0;
            end
         end
         S_CMD: begin
            if (w_cs_rise) begin
               w_state_next = S_IDLE;
               w_abort_next = (r_cnt != '0);
               w_cnt_next   = '0;
            end else if (w_sample) begin
               w_shift_next = w_shift_in;
               if (r_cnt == CMD_LAST) begin
                  w_cnt_next   = '0;
                  w_state_next = S_LOAD;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (w_cs_rise) begin
               w_state_next = S_IDLE;
            end else begin
               w_addr_next = r_shift[ADDR_W-1:0];
               if (r_shift[ADDR_W]) begin
                  w_rd_en_next = 1'b1;
                  w_state_next = S_READ;
               end else begin
                  w_state_next = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (w_cs_rise) begin
               w_state_next = S_IDLE;
               w_abort_next = (r_cnt != '0);
               w_cnt_next   = '0;
            end else if (w_sample) begin
               w_shift_next = w_shift_in;
               if (r_cnt == DATA_LAST) begin
                  w_cnt_next     = '0;
                  w_data_wr_next = w_shift_in[DATA_W-1:0];
                  w_wr_en_next   = 1'b1;
                  w_state_next   = S_WR_INC;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_WR_INC: begin
            if (w_cs_rise) begin
               w_state_next = S_IDLE;
            end else if (BURST_EN != 0) begin
               w_addr_next  = r_addr + 1'b1;
               w_state_next = S_WRITE;
            end else begin
               w_state_next = S_DONE;
            end
         end
         S_READ: begin
            if (w_cs_rise) begin
               w_state_next = S_IDLE;
               w_abort_next = (r_cnt != '0);
               w_cnt_next   = '0;
            end else begin
               if (w_shift) begin
                  w_miso_next = r_tx[DATA_W-1];
                  w_tx_next   = {r_tx[DATA_W-2:0], 1'b0};
               end
               if (w_sample) begin
                  if (r_cnt == DATA_LAST) begin
                     w_cnt_next   = '0;
                     w_state_next = (BURST_EN != 0) ? S_RD_INC : S_DONE;
                  end else begin
                     w_cnt_next = r_cnt + 1'b1;
                  end
               end
            end
         end
         S_RD_INC: begin
            if (w_cs_rise) begin
               w_state_next = S_IDLE;
            end else begin
               w_addr_next  = r_addr + 1'b1;
               w_rd_en_next = 1'b1;
               w_state_next = S_READ;
            end
         end
         S_DONE: begin
            if (w_cs_rise) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      // Read data is valid while rd_en is high; capture it into the tx shifter then.
      if (r_rd_en) w_tx_next = bus.data_rd_i;
      // Looking one synchroniser stage ahead lets miso_oe fall together with synchronised cs.
      w_rd_state     = (w_state_next == S_READ) || (w_state_next == S_RD_INC);
      w_miso_oe_next = w_rd_state && !w_cs_pre;
      if (!w_miso_oe_next) w_miso_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= {SYNC_N{C_IDLE}};
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_sclk_d    <= C_IDLE;
         r_cs_d      <= 1'b1;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_tx        <= '0;
         r_addr      <= '0;
         r_data_wr   <= '0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_abort     <= 1'b0;
         r_miso      <= 1'b0;
         r_miso_oe   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_N-2:0], bus.sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_N-2:0], bus.mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_N-2:0], bus.cs};
         r_sclk_d    <= w_sclk_s;
         r_cs_d      <= w_cs_s;
         r_cnt       <= w_cnt_next;
         r_shift     <= w_shift_next;
         r_tx        <= w_tx_next;
         r_addr      <= w_addr_next;
         r_data_wr   <= w_data_wr_next;
         r_wr_en     <= w_wr_en_next;
         r_rd_en     <= w_rd_en_next;
         r_abort     <= w_abort_next;
         r_miso      <= w_miso_next;
         r_miso_oe   <= w_miso_oe_next;
      end
   end

   assign bus.miso    = r_miso;
   assign bus.miso_oe = r_miso_oe;
   assign bus.addr    = r_addr;
   assign bus.data_wr = r_data_wr;
   assign bus.wr_en   = r_wr_en;
   assign bus.rd_en   = r_rd_en;
   assign bus.abort   = r_abort;
endmodule

// File: tb/tb_spi_regif_slave.sv
// Scoreboard bench for spi_regif_slave: three instances (default mode 1 with burst,
// mode 0 with 16-bit data, and mode 1 without burst) share sclk/mosi and own a cs each.
`timescale 1ns/1ps
module tb_spi_regif_slave;
   localparam int Q = 40;
   localparam int H = 80;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic [2:0] cs_n = 3'b111;
   int         cur = 0;
   logic       cur_miso;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   spi_regif_slave_if #(.ADDR_W(7), .DATA_W(8))  if_def();
   spi_regif_slave_if #(.ADDR_W(7), .DATA_W(16)) if_m0();
   spi_regif_slave_if #(.ADDR_W(7), .DATA_W(8))  if_nb();

   spi_regif_slave #(.ADDR_W(7), .DATA_W(8), .CPOL(0), .CPHA(1), .SYNC_STAGES(2), .BURST_EN(1))
      u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
   spi_regif_slave #(.ADDR_W(7), .DATA_W(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(2), .BURST_EN(1))
      u_m0 (.clk(clk), .rst_n(rst_n), .bus(if_m0));
   spi_regif_slave #(.ADDR_W(7), .DATA_W(8), .CPOL(0), .CPHA(1), .SYNC_STAGES(2), .BURST_EN(0))
      u_nb (.clk(clk), .rst_n(rst_n), .bus(if_nb));

   // Register-file read model: a few hand-chosen values, address elsewhere.
   function automatic logic [15:0] rd_model(input logic [6:0] a);
      case (a)
         7'd3:    return 16'hBEEF;
         7'd5:    return 16'h003C;
         7'd6:    return 16'h00C3;
         default: return {9'h0, a};
      endcase
   endfunction

   function automatic logic [7:0] rd8(input logic [6:0] a);
      logic [15:0] t;
      t = rd_model(a);
      return t[7:0];
   endfunction

   assign if_def.sclk = sclk;
   assign if_m0.sclk  = sclk;
   assign if_nb.sclk  = sclk;
   assign if_def.mosi = mosi;
   assign if_m0.mosi  = mosi;
   assign if_nb.mosi  = mosi;
   assign if_def.cs   = cs_n[0];
   assign if_m0.cs    = cs_n[1];
   assign if_nb.cs    = cs_n[2];
   assign if_def.data_rd_i = rd8(if_def.addr);
   assign if_m0.data_rd_i  = rd_model(if_m0.addr);
   assign if_nb.data_rd_i  = rd8(if_nb.addr);

   always_comb begin
      case (cur)
         0:       cur_miso = if_def.miso;
         1:       cur_miso = if_m0.miso;
         default: cur_miso = if_nb.miso;
      endcase
   end

   // kind: 0 = write strobe, 1 = read strobe, 2 = abort pulse
   typedef struct {
      int          kind;
      int          dut;
      logic [6:0]  addr;
      logic [15:0] data;
   } evt_t;
   evt_t exp_q[$];

   task automatic push(input int kind, input int dut, input logic [6:0] a, input logic [15:0] d);
      evt_t e;
      e.kind = kind; e.dut = dut; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic got(input int kind, input int dut, input logic [6:0] a, input logic [15:0] d);
      evt_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d dut=%0d addr=%0h data=%0h, required none", kind, dut, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.dut != dut || (kind != 2 && e.addr != a) || (kind == 0 && e.data != d)) begin
            errors++;
            $display("FAIL event: got kind=%0d dut=%0d addr=%0h data=%0h, required kind=%0d dut=%0d addr=%0h data=%0h",
                     kind, dut, a, d, e.kind, e.dut, e.addr, e.data);
         end else begin
            $display("event ok: kind=%0d dut=%0d addr=%0h data=%0h", kind, dut, a, d);
         end
      end
   endtask

   // Monitor: every strobe any instance presents is matched against the queue.
   always @(negedge clk) begin
      if (if_def.wr_en) got(0, 0, if_def.addr, {8'h00, if_def.data_wr});
      if (if_def.rd_en) got(1, 0, if_def.addr, 16'h0);
      if (if_def.abort) got(2, 0, 7'h0, 16'h0);
      if (if_m0.wr_en)  got(0, 1, if_m0.addr, if_m0.data_wr);
      if (if_m0.rd_en)  got(1, 1, if_m0.addr, 16'h0);
      if (if_m0.abort)  got(2, 1, 7'h0, 16'h0);
      if (if_nb.wr_en)  got(0, 2, if_nb.addr, {8'h00, if_nb.data_wr});
      if (if_nb.rd_en)  got(1, 2, if_nb.addr, 16'h0);
      if (if_nb.abort)  got(2, 2, 7'h0, 16'h0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end else begin
         $display("check ok: %s = %0h", name, act);
      end
   endtask

   task automatic cs_low(input int d);
      cur = d;
      cs_n[d] = 1'b0;
      #H;
   endtask

   task automatic cs_high(input int d);
      #H;
      cs_n[d] = 1'b1;
      #(2*H);
   endtask

   // One SPI word, MSB first; mosi changes a quarter period away from either sclk edge.
   task automatic xfer(input logic [15:0] tx, input int n, output logic [15:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         mosi = tx[i];
         #Q;
         if (cur == 1) rx = {rx[14:0], cur_miso};
         sclk = 1'b1;
         #H;
         if (cur != 1) rx = {rx[14:0], cur_miso};
         sclk = 1'b0;
         #Q;
      end
   endtask

   logic [15:0] rx;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs_def", {if_def.miso, if_def.miso_oe, if_def.wr_en, if_def.rd_en, if_def.abort, if_def.addr, if_def.data_wr}, 32'h0);
      chk("reset_outputs_m0", {if_m0.miso, if_m0.miso_oe, if_m0.wr_en, if_m0.rd_en, if_m0.abort, if_m0.addr, if_m0.data_wr}, 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single write, mode 1
      cs_low(0);
      push(0, 0, 7'h12, 16'h00A5);
      xfer(16'h12, 8, rx);
      xfer(16'hA5, 8, rx);
      cs_high(0);
      chk("write_data_hold", {24'h0, if_def.data_wr}, 32'hA5);
      chk("write_addr_after_burst_inc", {25'h0, if_def.addr}, 32'h13);

      // Read addr 5, burst enabled so addr 6 is prefetched after the word
      cs_low(0);
      push(1, 0, 7'h05, 16'h0);
      push(1, 0, 7'h06, 16'h0);
      xfer(16'h85, 8, rx);
      xfer(16'h00, 8, rx);
      chk("read_miso_oe_active", {31'h0, if_def.miso_oe}, 32'h1);
      chk("read_miso_word", {16'h0, rx}, 32'h3C);
      cs_high(0);
      chk("read_miso_oe_after_cs", {31'h0, if_def.miso_oe}, 32'h0);
      chk("read_miso_after_cs", {31'h0, if_def.miso}, 32'h0);

      // Burst write with address wrap
      cs_low(0);
      push(0, 0, 7'h7E, 16'h0011);
      push(0, 0, 7'h7F, 16'h0022);
      push(0, 0, 7'h00, 16'h0033);
      xfer(16'h7E, 8, rx);
      xfer(16'h11, 8, rx);
      xfer(16'h22, 8, rx);
      xfer(16'h33, 8, rx);
      cs_high(0);
      chk("burst_addr_after_wrap", {25'h0, if_def.addr}, 32'h01);

      // Mode 0, 16-bit read of addr 3
      cs_low(1);
      push(1, 1, 7'h03, 16'h0);
      push(1, 1, 7'h04, 16'h0);
      xfer(16'h83, 8, rx);
      xfer(16'h0000, 16, rx);
      chk("m0_read_miso_word", {16'h0, rx}, 32'hBEEF);
      cs_high(1);
      chk("m0_miso_oe_after_cs", {31'h0, if_m0.miso_oe}, 32'h0);

      // Partial write word then a clean frame
      cs_low(0);
      push(2, 0, 7'h00, 16'h0);
      xfer(16'h20, 8, rx);
      xfer(16'h0A, 4, rx);
      cs_high(0);
      cs_low(0);
      push(0, 0, 7'h21, 16'h0099);
      xfer(16'h21, 8, rx);
      xfer(16'h99, 8, rx);
      cs_high(0);

      // No burst: second data word ignored; reset mid-frame clears outputs
      cs_low(2);
      push(0, 2, 7'h01, 16'h005A);
      xfer(16'h01, 8, rx);
      xfer(16'h5A, 8, rx);
      xfer(16'hC3, 8, rx);
      chk("nb_data_hold", {24'h0, if_nb.data_wr}, 32'h5A);
      chk("nb_addr_no_inc", {25'h0, if_nb.addr}, 32'h01);
      @(negedge clk);
      rst_n = 1'b0;
      #20;
      chk("midframe_reset_nb", {if_nb.miso, if_nb.miso_oe, if_nb.wr_en, if_nb.rd_en, if_nb.abort, if_nb.addr, if_nb.data_wr}, 32'h0);
      chk("midframe_reset_def", {if_def.miso, if_def.miso_oe, if_def.wr_en, if_def.rd_en, if_def.abort, if_def.addr, if_def.data_wr}, 32'h0);
      rst_n = 1'b1;
      #(2*H);
      cs_high(2);

      // No burst read: exactly one rd_en
      cs_low(2);
      push(1, 2, 7'h05, 16'h0);
      xfer(16'h85, 8, rx);
      xfer(16'h00, 8, rx);
      chk("nb_read_miso_word", {16'h0, rx}, 32'h3C);
      cs_high(2);

      #(2*H);
      chk("pending_events", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
